// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAM search-side match encoder.
package cam_pkg;

  typedef enum logic [0:0] {
    CAM_ENC_IDLE,
    CAM_ENC_BUSY
  } cam_enc_state_e;

  // Widest vector popcount() can count; callers zero-extend to this width.
  localparam int unsigned PopcountMaxWidth = 1024;

  // Counts set bits in v[width-1:0].
  function automatic int unsigned popcount(input logic [PopcountMaxWidth-1:0] v,
                                           input int unsigned width);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < PopcountMaxWidth; i++) begin
      if (i < width && v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cam_priority_encoder.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set bit in vec.
module cam_priority_encoder #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic [DEPTH-1:0]      vec_i,
  output logic [ADDR_WIDTH-1:0] index_o,
  output logic                  any_o
);

  always_comb begin
    index_o = '0;
    any_o   = 1'b0;
    // Scan high to low so the lowest set bit wins.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        index_o = ADDR_WIDTH'(i);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_match_encoder.sv
// Captures one CAM match vector per search and streams every matching entry index,
// lowest first, over a valid/ready handshake; reports misses and the hit count.
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  match_valid_i,
  output logic                  match_ready_o,
  input  logic [DEPTH-1:0]      match_vector_i,
  output logic [ADDR_WIDTH-1:0] index_o,
  output logic                  index_valid_o,
  input  logic                  index_ready_i,
  output logic                  index_last_o,
  output logic                  miss_o,
  output logic [ADDR_WIDTH:0]   hit_count_o
);

  cam_enc_state_e        state_q;
  logic [DEPTH-1:0]      pending_q;
  logic [ADDR_WIDTH:0]   hit_count_q;
  logic                  miss_q;

  logic [ADDR_WIDTH-1:0] enc_index;
  logic                  enc_any;
  logic                  busy;
  logic                  accept;
  logic                  last;
  logic                  handshake;

  cam_priority_encoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_prio_enc (
    .vec_i   (pending_q),
    .index_o (enc_index),
    .any_o   (enc_any)
  );

  assign busy      = (state_q == CAM_ENC_BUSY);
  assign accept    = match_valid_i && !busy;
  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign last      = ((pending_q & (pending_q - DEPTH'(1))) == '0);
  assign handshake = busy && index_ready_i;

  assign match_ready_o = !busy;
  assign index_valid_o = busy && enc_any;
  assign index_o       = busy ? enc_index : '0;
  assign index_last_o  = busy && last;
  assign miss_o        = miss_q;
  assign hit_count_o   = hit_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CAM_ENC_IDLE;
      pending_q   <= '0;
      hit_count_q <= '0;
      miss_q      <= 1'b0;
    end else begin
      miss_q <= 1'b0;
      unique case (state_q)
        CAM_ENC_IDLE: begin
          if (accept) begin
            hit_count_q <= (ADDR_WIDTH + 1)'(popcount(PopcountMaxWidth'(match_vector_i), DEPTH));
            if (match_vector_i == '0) begin
              miss_q <= 1'b1;
            end else begin
              pending_q <= match_vector_i;
              state_q   <= CAM_ENC_BUSY;
            end
          end
        end
        CAM_ENC_BUSY: begin
          if (handshake) begin
            pending_q[enc_index] <= 1'b0;
            if (last) state_q <= CAM_ENC_IDLE;
          end
        end
        default: state_q <= CAM_ENC_IDLE;
      endcase
    end
  end

endmodule
